// File: rtl/regfile_fwd.sv
// Register file with writeback write-through, EX/MEM destination scoreboard,
// forwarding selects, load-use stall detection and a saturating stall counter.
// Latency: reads, fwd_*, stall and v0 are combinational; a WB write is visible
// in the array after the clock edge and is bypassed to ID reads in its own cycle.
// Backpressure: stall holds PC and IF/ID for one cycle and inserts a bubble into EX.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   RA/RB, use_a/use_b       ID source addresses and whether they are read
//   RW, id_we, id_load       ID destination, write enable, load flag
//   id_valid, flush          ID slot occupancy and branch/jump kill
//   wb_we, wb_rw, wb_data    writeback commit
//   rd_a, rd_b, v0           read data (write-through applied)
//   fwd_a, fwd_b             0 = regfile, 1 = EX/MEM, 2 = MEM/WB
//   stall, stall_cnt         load-use hazard and saturating stall-cycle total
// Optional: define REGFILE_DEBUG_PORT_EN to add dbg_addr/dbg_data, a raw
// combinational read of the array (no write-through) for board display.
module regfile_fwd #(
    parameter int DW     = 32,
    parameter int NREG   = 32,
    parameter int V0_IDX = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    RA,
    input  logic [4:0]    RB,
    input  logic          use_a,
    input  logic          use_b,
    input  logic [4:0]    RW,
    input  logic          id_we,
    input  logic          id_load,
    input  logic          id_valid,
    input  logic          flush,
    input  logic          wb_we,
    input  logic [4:0]    wb_rw,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] rd_a,
    output logic [DW-1:0] rd_b,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b,
    output logic          stall,
    output logic [DW-1:0] v0,
    output logic [31:0]   stall_cnt
`ifdef REGFILE_DEBUG_PORT_EN
    ,
    input  logic [4:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
`endif
);

    localparam logic [4:0] V0_ADDR = 5'(V0_IDX);

    logic [DW-1:0] regs [NREG];

    // Scoreboard tags for the instructions currently in EX and MEM.
    // MEM needs no load flag: a load there forwards like any other result.
    logic       ex_vld;
    logic [4:0] ex_rw;
    logic       ex_load;
    logic       mem_vld;
    logic [4:0] mem_rw;

    // $0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we && (wb_rw != 5'd0)) begin
            regs[wb_rw] <= wb_data;
        end
    end

    // Same-cycle WB data wins over the stored value so ID never sees stale data.
    function automatic logic [DW-1:0] wt_read(
        input logic [4:0]    addr,
        input logic [DW-1:0] stored,
        input logic          we,
        input logic [4:0]    wrw,
        input logic [DW-1:0] wdata
    );
        if (addr == 5'd0) begin
            return '0;
        end
        if (we && (wrw == addr)) begin
            return wdata;
        end
        return stored;
    endfunction

    assign rd_a = wt_read(RA, regs[RA], wb_we, wb_rw, wb_data);
    assign rd_b = wt_read(RB, regs[RB], wb_we, wb_rw, wb_data);
    assign v0   = wt_read(V0_ADDR, regs[V0_ADDR], wb_we, wb_rw, wb_data);

    // A load in EX has no data yet, so it never forwards from EX; that case is
    // covered by the stall, after which the load sits in MEM and selects 2.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] addr,
        input logic       e_vld,
        input logic       e_load,
        input logic [4:0] e_rw,
        input logic       m_vld,
        input logic [4:0] m_rw
    );
        if (addr == 5'd0) begin
            return 2'd0;
        end
        if (e_vld && !e_load && (e_rw == addr)) begin
            return 2'd1;
        end
        if (m_vld && (m_rw == addr)) begin
            return 2'd2;
        end
        return 2'd0;
    endfunction

    assign fwd_a = fwd_sel(RA, ex_vld, ex_load, ex_rw, mem_vld, mem_rw);
    assign fwd_b = fwd_sel(RB, ex_vld, ex_load, ex_rw, mem_vld, mem_rw);

    assign stall = id_valid && !flush && ex_vld && ex_load && (ex_rw != 5'd0) &&
                   ((use_a && (ex_rw == RA)) || (use_b && (ex_rw == RB)));

    // A stalled or flushed ID instruction enters EX as a bubble; the bubble is
    // what lets the held instruction proceed after exactly one stall cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_vld  <= 1'b0;
            ex_rw   <= 5'd0;
            ex_load <= 1'b0;
            mem_vld <= 1'b0;
            mem_rw  <= 5'd0;
        end else begin
            ex_vld  <= id_valid && id_we && !stall && !flush;
            ex_rw   <= RW;
            ex_load <= id_load;
            mem_vld <= ex_vld;
            mem_rw  <= ex_rw;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

`ifdef REGFILE_DEBUG_PORT_EN
    assign dbg_data = regs[dbg_addr];
`endif

endmodule
